uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning prescaler ticks per bit (even, at least 4).
REQ-003 SHALL have parameter DLR_WIDTH, default 16, meaning baud divisor width.
REQ-004 SHALL have port apb_clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port apb_rstn_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_en_in, input, 1 bit: FIFO write strobe.
REQ-007 SHALL have port wr_data_in, input, 8 bits: FIFO write data.
REQ-008 SHALL have port dlr_in, input, DLR_WIDTH bits: clocks per prescaler tick.
REQ-009 SHALL have port wls_in, input, 2 bits: word length (00 = 5 bits to 11 = 8 bits).
REQ-010 SHALL have ports pen_in, eps_in, sp_in, stb_in, bc_in, afe_in, enable_in, txclr_in, each input, 1 bit, meaning parity enable, even parity, stick parity, long stop, break, auto-flow enable, transmit enable and FIFO clear.
REQ-011 SHALL have port cts_in, input, 1 bit: clear-to-send, high = clear.
REQ-012 SHALL have port uart_txd_out, output, 1 bit: serial line, idle high.
REQ-013 SHALL have ports fifo_full_out, thre_out and temt_out, each output, 1 bit: FIFO full, FIFO empty, and FIFO empty AND shifter idle.
REQ-014 SHALL have port fifo_level_out, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port overflow_out, output, 1 bit: one-clock pulse on a dropped write.

Function
REQ-016 SHALL run a prescaler that counts 0..dlr_in-1 and emits a one-clock tick at terminal count; dlr_in = 0 emits no ticks, and the frame freezes in its current state.
REQ-017 SHALL define bit time as OVERSAMPLE ticks (dlr_in*OVERSAMPLE clocks).
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL leave IDLE when FIFO is non-empty AND enable_in = 1 AND (afe_in = 0 OR cts_in = 1).
- On that cycle: pop the head word, restart the prescaler at 0, enter START.
- uart_txd_out goes low on the next clock.
REQ-020 SHALL send DATA LSB first for 5+wls_in bits, then PARITY only when pen_in = 1, then STOP.
REQ-021 SHALL sample wls_in, pen_in, eps_in, sp_in and stb_in at the pop and hold them for the whole frame.
REQ-022 SHALL compute the parity bit as follows:
- sp=0, eps=1: XOR of data bits (even parity).
- sp=0, eps=0: inverted XOR of data bits (odd parity).
- sp=1, eps=0: constant 1.
- sp=1, eps=1: constant 0.
REQ-023 SHALL set stop length to 1 bit when stb=0, OVERSAMPLE*3/2 ticks when stb=1 and 5-bit words, and 2 bits otherwise.
REQ-024 SHALL, at the end of STOP, evaluate the REQ-019 condition in the same cycle and go back-to-back into START with no idle gap if it holds, else go to IDLE.
REQ-025 SHALL NOT re-check cts_in or enable_in mid-frame; deasserting either only blocks the next pop.
REQ-026 SHALL force uart_txd_out low combinationally-registered (next clock) while bc_in = 1; the FSM and FIFO continue unaffected.
REQ-027 SHALL handle writes at the FIFO boundary as follows:
- A write when full is dropped and pulses overflow_out, even if a pop occurs in the same cycle.
- Write and pop in the same cycle when non-full: both take effect and the level is unchanged.
REQ-028 SHALL, on txclr_in = 1, empty the FIFO in one clock (pointers and level to 0).
- Same-cycle writes are dropped without an overflow pulse.
- A frame already in the shifter completes.
REQ-029 SHALL wrap pointers modulo FIFO_DEPTH, with fifo_full_out = (level == FIFO_DEPTH) and thre_out = (level == 0).
REQ-030 SHALL register all outputs.

Reset
REQ-031 SHALL, while apb_rstn_in = 0, set uart_txd_out=1, fifo_full_out=0, thre_out=1, temt_out=1, fifo_level_out=0, overflow_out=0, FSM=IDLE and prescaler=0.
REQ-032 SHALL, on a reset assertion mid-frame, abort the frame immediately and drive the line high; the FIFO contents are lost.

Verification
REQ-033 SHALL cover: dlr=1, 8N1 (wls=11, pen=0, stb=0), write 0x55 -> txd low 16 clk, then 1,0,1,0,1,0,1,0 at 16 clk each, high 16 clk; temt_out rises 160 clk after the start edge.
REQ-034 SHALL cover: dlr=2, 7E1 (wls=10, pen=1, eps=1), write 0x03 -> parity bit 0; frame = 10 bits = 320 clk; with eps=0 the parity bit = 1.
REQ-035 SHALL cover: 5-bit words, stb=1, dlr=1 -> stop high exactly 24 clk before the next start; 8-bit words, stb=1 -> stop 32 clk.
REQ-036 SHALL cover: FIFO_DEPTH=16, 17 writes with enable_in=0 -> fifo_full_out=1, level=16, one overflow_out pulse; then enable_in=1 -> 16 frames back-to-back with no idle gap.
REQ-037 SHALL cover: afe_in=1, cts_in=0 with 2 words queued -> line stays high; raise cts_in -> start bit next clock; drop cts_in mid-frame -> frame completes and the second word is held.
REQ-038 SHALL cover: txclr_in during a frame with 3 words queued -> level=0 next clock and the current frame finishes intact; reset mid-DATA -> txd=1 and temt_out=1 immediately.

Source files
------------

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//   UART transmitter with a transmit FIFO, a programmable baud prescaler and a
//   frame FSM (start, 5..8 data bits LSB first, optional parity, 1/1.5/2 stop).
//
// Ports
//   apb_clk_in       single clock
//   apb_rstn_in      asynchronous active-low reset
//   wr_en_in         FIFO write strobe
//   wr_data_in       FIFO write data
//   dlr_in           clocks per prescaler tick (0 = no ticks, frame frozen)
//   wls_in           word length, 00 = 5 bits .. 11 = 8 bits
//   pen_in           parity enable
//   eps_in           even parity select
//   sp_in            stick parity
//   stb_in           long stop (1.5 bits for 5-bit words, else 2 bits)
//   bc_in            break: forces the line low, FSM/FIFO keep running
//   afe_in           auto-flow enable (gate frame starts on cts_in)
//   enable_in        transmit enable (gates frame starts only)
//   txclr_in         FIFO clear
//   cts_in           clear-to-send, high = clear
//   uart_txd_out     serial line, idle high
//   fifo_full_out    FIFO holds FIFO_DEPTH words
//   thre_out         FIFO empty
//   temt_out         FIFO empty and shifter idle
//   fifo_level_out   FIFO occupancy
//   overflow_out     one-clock pulse when a write is dropped because of full
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DLR_WIDTH  = 16
) (
    input  logic                          apb_clk_in,
    input  logic                          apb_rstn_in,
    input  logic                          wr_en_in,
    input  logic [7:0]                    wr_data_in,
    input  logic [DLR_WIDTH-1:0]          dlr_in,
    input  logic [1:0]                    wls_in,
    input  logic                          pen_in,
    input  logic                          eps_in,
    input  logic                          sp_in,
    input  logic                          stb_in,
    input  logic                          bc_in,
    input  logic                          afe_in,
    input  logic                          enable_in,
    input  logic                          txclr_in,
    input  logic                          cts_in,
    output logic                          uart_txd_out,
    output logic                          fifo_full_out,
    output logic                          thre_out,
    output logic                          temt_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Tick counter must reach the longest bit period, i.e. a 2-bit stop.
    localparam int TW    = $clog2(2 * OVERSAMPLE) + 1;

    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);
    localparam logic [TW-1:0]    BIT_TICKS = TW'(OVERSAMPLE);
    localparam logic [TW-1:0]    STOP_1P5  = TW'(OVERSAMPLE * 3 / 2);
    localparam logic [TW-1:0]    STOP_2    = TW'(OVERSAMPLE * 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity over the active data bits; stick parity ignores the data.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] wls,
                                        input logic eps, input logic sp);
        logic [7:0] m;
        case (wls)
            2'b00:   m = 8'h1F;
            2'b01:   m = 8'h3F;
            2'b10:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        if (sp) begin
            return ~eps;
        end
        return eps ? (^(d & m)) : ~(^(d & m));
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, thre_q, temt_q, ovf_q, txd_q;
    logic                 full_d, thre_d, temt_d, ovf_d, txd_d;

    logic [DLR_WIDTH-1:0] pre_q, pre_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]           bitn_q, bitn_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [1:0]           wls_q, wls_d;
    logic                 pen_q, pen_d;
    logic                 stb_q, stb_d;

    logic                 pop;
    logic                 start_ok;
    logic                 wr_ok;
    logic                 fifo_full;
    logic                 tick;
    logic                 pre_term;
    logic                 bit_end;
    logic [TW-1:0]        stop_len;
    logic [TW-1:0]        bit_len;
    logic [7:0]           head;

    assign fifo_full = (level_q == DEPTH_L);
    assign head      = mem_q[rd_ptr_q];
    assign start_ok  = (level_q != '0) && enable_in && (!afe_in || cts_in);
    assign wr_ok     = wr_en_in && !fifo_full && !txclr_in;

    // ---------------------------------------------------------------------
    // Prescaler: one-clock tick at terminal count; restarted by every pop.
    // '>=' keeps the counter from running the long way round if dlr_in is
    // lowered below the current count.
    // ---------------------------------------------------------------------
    assign pre_term = (pre_q >= (dlr_in - DLR_WIDTH'(1)));
    assign tick     = (dlr_in != '0) && pre_term;

    always_comb begin
        pre_d = pre_q;
        if (pop) begin
            pre_d = '0;
        end else if (dlr_in != '0) begin
            pre_d = pre_term ? '0 : pre_q + DLR_WIDTH'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    always_comb begin
        case ({stb_q, (wls_q == 2'b00)})
            2'b11:   stop_len = STOP_1P5;
            2'b10:   stop_len = STOP_2;
            default: stop_len = BIT_TICKS;
        endcase
    end

    assign bit_len = (state_q == STOP) ? stop_len : BIT_TICKS;
    assign bit_end = tick && (tcnt_q == (bit_len - TW'(1)));

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        wls_d   = wls_q;
        pen_d   = pen_q;
        stb_d   = stb_q;
        pop     = 1'b0;

        if ((state_q != IDLE) && tick) begin
            tcnt_d = bit_end ? '0 : tcnt_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bitn_d  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitn_q == (3'd4 + {1'b0, wls_q})) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: no idle bit between stop and start.
                    if (start_ok) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame format is latched at the pop and held for the whole frame.
        if (pop) begin
            state_d = START;
            tcnt_d  = '0;
            shreg_d = head;
            par_d   = parity_bit(head, wls_in, eps_in, sp_in);
            wls_d   = wls_in;
            pen_d   = pen_in;
            stb_d   = stb_in;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO bookkeeping. Clear wins over everything, including the write;
    // a pop in the same cycle still hands its word to the shifter.
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (txclr_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(wr_ok) - LVL_W'(pop);
        end
    end

    // ---------------------------------------------------------------------
    // Output next-state: every output is a register fed from next-state.
    // ---------------------------------------------------------------------
    always_comb begin
        full_d = (level_d == DEPTH_L);
        thre_d = (level_d == '0);
        temt_d = (level_d == '0) && (state_d == IDLE);
        ovf_d  = wr_en_in && fifo_full && !txclr_in;

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
        if (bc_in) begin
            txd_d = 1'b0;
        end
    end

    // FIFO storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge apb_clk_in) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_in;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            thre_q   <= 1'b1;
            temt_q   <= 1'b1;
            ovf_q    <= 1'b0;
            txd_q    <= 1'b1;
            pre_q    <= '0;
            state_q  <= IDLE;
            tcnt_q   <= '0;
            bitn_q   <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            wls_q    <= '0;
            pen_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            thre_q   <= thre_d;
            temt_q   <= temt_d;
            ovf_q    <= ovf_d;
            txd_q    <= txd_d;
            pre_q    <= pre_d;
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bitn_q   <= bitn_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            wls_q    <= wls_d;
            pen_q    <= pen_d;
            stb_q    <= stb_d;
        end
    end

    assign uart_txd_out   = txd_q;
    assign fifo_full_out  = full_q;
    assign thre_out       = thre_q;
    assign temt_out       = temt_q;
    assign fifo_level_out = level_q;
    assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//   Scoreboard bench for uart_tx_core. Each accepted write pushes the expected
//   frame (data, parity, bit and stop lengths) into a queue; a line monitor
//   pops it at every start edge and compares the whole serial waveform.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_core;

    localparam int DEPTH = 16;
    localparam int OS    = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [15:0] dlr = 16'd1;
    logic [1:0]  wls = 2'b11;
    logic        pen = 1'b0, eps = 1'b0, sp = 1'b0, stb = 1'b0;
    logic        bc = 1'b0, afe = 1'b0, enable = 1'b0, txclr = 1'b0, cts = 1'b0;
    logic        txd, full, thre, temt, ovf;
    logic [4:0]  level;

    uart_tx_core #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .DLR_WIDTH(16)) dut (
        .apb_clk_in     (clk),
        .apb_rstn_in    (rstn),
        .wr_en_in       (wr_en),
        .wr_data_in     (wr_data),
        .dlr_in         (dlr),
        .wls_in         (wls),
        .pen_in         (pen),
        .eps_in         (eps),
        .sp_in          (sp),
        .stb_in         (stb),
        .bc_in          (bc),
        .afe_in         (afe),
        .enable_in      (enable),
        .txclr_in       (txclr),
        .cts_in         (cts),
        .uart_txd_out   (txd),
        .fifo_full_out  (full),
        .thre_out       (thre),
        .temt_out       (temt),
        .fifo_level_out (level),
        .overflow_out   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         pen;
        bit         par;
        int         bt;
        int         stop_clks;
    } frame_t;

    frame_t sb[$];
    int     starts[$];
    bit     mon_en = 1'b1;
    bit     mon_busy = 1'b0;
    int     ovf_cnt = 0;

    always @(negedge clk) if (ovf === 1'b1) ovf_cnt++;

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -100000;
    endfunction

    // Expected frame from the configuration currently on the inputs.
    task automatic push_exp(input logic [7:0] d);
        frame_t f;
        int ones;
        f.data  = d;
        f.nbits = 5 + int'(wls);
        f.pen   = pen;
        f.bt    = int'(dlr) * OS;
        ones = 0;
        for (int i = 0; i < f.nbits; i++) ones += int'(d[i]);
        if (sp)       f.par = !eps;
        else if (eps) f.par = (ones % 2 == 1);
        else          f.par = (ones % 2 == 0);
        if (!stb)             f.stop_clks = f.bt;
        else if (f.nbits == 5) f.stop_clks = f.bt * 3 / 2;
        else                  f.stop_clks = f.bt * 2;
        sb.push_back(f);
    endtask

    // Called at a negedge; leaves at the next negedge with the strobe low.
    task automatic write_word(input logic [7:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) push_exp(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs from the negedge that saw the start edge through the last stop sample.
    task automatic check_frame();
        frame_t     f;
        int         nb, total, errs;
        logic [7:0] got, expd;
        logic       exp_b;
        bit         aborted;
        if (sb.size() == 0) begin
            check_eq("frame_expected", 0, 1);
            return;
        end
        f     = sb.pop_front();
        nb    = 1 + f.nbits + (f.pen ? 1 : 0);
        total = nb * f.bt + f.stop_clks;
        expd  = f.data & 8'((1 << f.nbits) - 1);
        errs = 0; got = 8'h00; aborted = 1'b0;
        for (int s = 0; s < total; s++) begin
            int b;
            if (s > 0) @(negedge clk);
            if (!rstn) begin
                aborted = 1'b1;
                break;
            end
            b = s / f.bt;
            if (b == 0)                          exp_b = 1'b0;
            else if (b <= f.nbits)               exp_b = f.data[b-1];
            else if (f.pen && b == f.nbits + 1)  exp_b = f.par;
            else                                 exp_b = 1'b1;
            if (txd !== exp_b) errs++;
            if (b >= 1 && b <= f.nbits && (s % f.bt) == f.bt / 2) got[b-1] = txd;
        end
        if (!aborted) begin
            check_eq("frame_wave", errs, 0);
            check_eq("frame_data", int'(got), int'(expd));
        end
    endtask

    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rstn && prev === 1'b1 && txd === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                check_frame();
                mon_busy = 1'b0;
            end
            prev = txd;
        end
    end

    task automatic wait_idle(input string tag, input int bound);
        int n;
        bit done;
        n = 0;
        done = temt && sb.size() == 0 && !mon_busy;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
            done = temt && sb.size() == 0 && !mon_busy;
        end
        check_eq(tag, int'(done), 1);
    endtask

    task automatic wait_start(input string tag, input int n0, input int bound);
        int n;
        n = 0;
        while (starts.size() <= n0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq(tag, int'(starts.size() > n0), 1);
    endtask

    task automatic temt_rise(output int rise);
        int n;
        n = 0;
        rise = -1;
        while (!temt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (temt) rise = cyc;
    endtask

    task automatic sample_at(input int c, output logic v);
        int n;
        n = 0;
        while (cyc < c && n < 5000) begin
            @(negedge clk);
            n++;
        end
        v = txd;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n0, wr_cyc, rise, bad, cts_cyc, s0, ovf0;
        logic v;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_txd",   int'(txd),   1);
        check_eq("rst_full",  int'(full),  0);
        check_eq("rst_thre",  int'(thre),  1);
        check_eq("rst_temt",  int'(temt),  1);
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_ovf",   int'(ovf),   0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, dlr=1, 0x55
        dlr = 16'd1; wls = 2'b11; pen = 1'b0; stb = 1'b0; enable = 1'b1;
        n0 = starts.size();
        wr_cyc = cyc + 1;
        write_word(8'h55, 1'b1);
        temt_rise(rise);
        check_eq("8n1_latency", start_at(n0) - wr_cyc, 1);
        check_eq("8n1_temt", rise - start_at(n0), 160);
        wait_idle("8n1_idle", 500);

        // 7E1 / 7O1, dlr=2, 0x03
        dlr = 16'd2; wls = 2'b10; pen = 1'b1; eps = 1'b1;
        n0 = starts.size();
        write_word(8'h03, 1'b1);
        wait_start("7e1_start", n0, 100);
        sample_at(start_at(n0) + 8 * 32 + 16, v);
        check_eq("7e1_parity", int'(v), 0);
        temt_rise(rise);
        check_eq("7e1_frame_len", rise - start_at(n0), 320);
        wait_idle("7e1_idle", 800);
        eps = 1'b0;
        n0 = starts.size();
        write_word(8'h03, 1'b1);
        wait_start("7o1_start", n0, 100);
        sample_at(start_at(n0) + 8 * 32 + 16, v);
        check_eq("7o1_parity", int'(v), 1);
        wait_idle("7o1_idle", 800);

        // Stick parity, 6-bit words
        dlr = 16'd1; wls = 2'b01; sp = 1'b1; eps = 1'b0;
        write_word(8'h2A, 1'b1);
        wait_idle("stick1_idle", 500);
        eps = 1'b1;
        write_word(8'h15, 1'b1);
        wait_idle("stick0_idle", 500);
        sp = 1'b0; pen = 1'b0; eps = 1'b0;

        // Long stop: 5-bit -> 24 clk, 8-bit -> 32 clk, back-to-back
        wls = 2'b00; stb = 1'b1; enable = 1'b0;
        write_word(8'h15, 1'b1);
        write_word(8'h0A, 1'b1);
        n0 = starts.size();
        enable = 1'b1;
        wait_idle("stop15_idle", 800);
        check_eq("stop15_gap", start_at(n0 + 1) - start_at(n0), 6 * 16 + 24);
        wls = 2'b11; enable = 1'b0;
        write_word(8'hC3, 1'b1);
        write_word(8'h3C, 1'b1);
        n0 = starts.size();
        enable = 1'b1;
        wait_idle("stop2_idle", 800);
        check_eq("stop2_gap", start_at(n0 + 1) - start_at(n0), 9 * 16 + 32);
        stb = 1'b0;

        // FIFO full, overflow, 16 back-to-back frames
        enable = 1'b0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 17; i++) write_word(8'(i * 13 + 1), i < DEPTH);
        @(negedge clk);
        check_eq("fill_full",  int'(full),  1);
        check_eq("fill_level", int'(level), 16);
        check_eq("fill_thre",  int'(thre),  0);
        check_eq("fill_ovf",   ovf_cnt - ovf0, 1);
        n0 = starts.size();
        enable = 1'b1;
        wait_idle("b2b_idle", 16 * 160 + 200);
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (start_at(n0 + i) - start_at(n0 + i - 1) != 160) bad++;
        check_eq("b2b_gaps", bad, 0);
        check_eq("b2b_frames", starts.size() - n0, 16);

        // Auto flow control
        afe = 1'b1; cts = 1'b0;
        n0 = starts.size();
        write_word(8'hA5, 1'b1);
        write_word(8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("cts_hold_starts", starts.size() - n0, 0);
        check_eq("cts_hold_txd", int'(txd), 1);
        check_eq("cts_hold_level", int'(level), 2);
        cts_cyc = cyc + 1;
        cts = 1'b1;
        repeat (40) @(negedge clk);
        cts = 1'b0;
        check_eq("cts_start", start_at(n0) - cts_cyc, 0);
        s0 = start_at(n0);
        while (cyc < s0 + 160 + 100) @(negedge clk);
        check_eq("cts_second_held", starts.size() - n0, 1);
        check_eq("cts_level_held", int'(level), 1);
        cts = 1'b1;
        wait_idle("cts_idle", 600);
        check_eq("cts_frames", starts.size() - n0, 2);
        afe = 1'b0; cts = 1'b0;

        // FIFO clear mid-frame, with a same-cycle write that is dropped
        enable = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'h90 + i), 1'b1);
        n0 = starts.size();
        enable = 1'b1;
        wait_start("clr_start", n0, 100);
        s0 = start_at(n0);
        while (cyc < s0 + 50) @(negedge clk);
        check_eq("clr_level_before", int'(level), 3);
        ovf0 = ovf_cnt;
        txclr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        txclr = 1'b0; wr_en = 1'b0;
        sb.delete();
        check_eq("clr_level", int'(level), 0);
        check_eq("clr_thre", int'(thre), 1);
        @(negedge clk);
        check_eq("clr_no_ovf", ovf_cnt - ovf0, 0);
        wait_idle("clr_idle", 600);
        check_eq("clr_frames", starts.size() - n0, 1);

        // Reset mid-DATA
        n0 = starts.size();
        write_word(8'hC3, 1'b1);
        write_word(8'h5A, 1'b1);
        wait_start("rst_start", n0, 100);
        s0 = start_at(n0);
        while (cyc < s0 + 16 * 3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("midrst_txd",   int'(txd),   1);
        check_eq("midrst_temt",  int'(temt),  1);
        check_eq("midrst_level", int'(level), 0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("midrst_no_frame", starts.size() - n0, 1);

        // Break forces the line low; the FSM stays idle
        mon_en = 1'b0;
        bc = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("break_txd", int'(txd), 0);
        check_eq("break_temt", int'(temt), 1);
        bc = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("break_release", int'(txd), 1);
        mon_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
